// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small circular FIFO in front of the serial FSM.
// Frames are sent LSB first on an idle-high line, back-to-back while bytes are queued.
`timescale 1ns/1ps
module uart_tx #(
    parameter int DBIT         = 8,
    parameter int CLKS_PER_BIT = 2613,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [DBIT-1:0] TX_DATA,
    input  logic            TX_WR,
    output logic            TX_FULL,
    output logic            TX_EMPTY,
    output logic            TX_BUSY,
    output logic            TX_DONE,
    output logic            TX_OVF,
    output logic            TX
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int CW       = $clog2(STOP_LEN);
    localparam int IW       = $clog2(DBIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [DBIT-1:0] mem_r [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_r, rd_ptr_r;
    logic [AW:0]     wr_ptr_n_s, rd_ptr_n_s;
    logic            full_r, empty_r, ovf_r;
    logic            push_s, pop_s;
    logic [DBIT-1:0] head_s;

    state_t          state_r, state_n_s;
    logic [CW-1:0]   cnt_r, cnt_n_s;
    logic [IW-1:0]   idx_r, idx_n_s;
    logic [DBIT-1:0] shift_r, shift_n_s;
    logic            tx_r, tx_n_s;
    logic            busy_r, busy_n_s;
    logic            done_r, done_n_s;

    assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
    // A pop frees a slot in the same cycle, so a write into a full FIFO can still land.
    assign push_s     = TX_WR & (~full_r | pop_s);
    assign wr_ptr_n_s = push_s ? (wr_ptr_r + (AW+1)'(1)) : wr_ptr_r;
    assign rd_ptr_n_s = pop_s  ? (rd_ptr_r + (AW+1)'(1)) : rd_ptr_r;

    // FIFO storage write port.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= TX_DATA;
        end
    end

    // FIFO pointers, registered full/empty flags and sticky overflow.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
            empty_r  <= (wr_ptr_n_s == rd_ptr_n_s);
            full_r   <= (wr_ptr_n_s[AW] != rd_ptr_n_s[AW]) &&
                        (wr_ptr_n_s[AW-1:0] == rd_ptr_n_s[AW-1:0]);
            ovf_r    <= ovf_r | (TX_WR & full_r & ~pop_s);
        end
    end

    // Next-state, counters, shift register and next registered line value.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        idx_n_s   = idx_r;
        shift_n_s = shift_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_r) begin
                    pop_s     = 1'b1;
                    state_n_s = START;
                    cnt_n_s   = '0;
                    idx_n_s   = '0;
                    shift_n_s = head_s;
                end else begin
                    state_n_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                    state_n_s = DATA;
                    cnt_n_s   = '0;
                    idx_n_s   = '0;
                end else begin
                    cnt_n_s   = cnt_r + CW'(1);
                end
            end
            DATA: begin
                if (cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n_s   = '0;
                    shift_n_s = shift_r >> 1;
                    if (idx_r == IW'(DBIT - 1)) begin
                        state_n_s = STOP;
                        idx_n_s   = '0;
                    end else begin
                        idx_n_s   = idx_r + IW'(1);
                    end
                end else begin
                    cnt_n_s   = cnt_r + CW'(1);
                end
            end
            STOP: begin
                if (cnt_r == CW'(STOP_LEN - 1)) begin
                    cnt_n_s = '0;
                    // Chain straight into the next start bit when more data is waiting.
                    if (!empty_r) begin
                        pop_s     = 1'b1;
                        state_n_s = START;
                        idx_n_s   = '0;
                        shift_n_s = head_s;
                    end else begin
                        state_n_s = IDLE;
                    end
                end else begin
                    cnt_n_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_n_s = IDLE;
                cnt_n_s   = '0;
                idx_n_s   = '0;
            end
        endcase

        case (state_n_s)
            START:   tx_n_s = 1'b0;
            DATA:    tx_n_s = shift_n_s[0];
            default: tx_n_s = 1'b1;
        endcase
        busy_n_s = (state_n_s != IDLE);
        done_n_s = (state_n_s == STOP) && (cnt_n_s == CW'(STOP_LEN - 1));
    end

    // FSM state and registered serial outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            idx_r   <= idx_n_s;
            shift_r <= shift_n_s;
            tx_r    <= tx_n_s;
            busy_r  <= busy_n_s;
            done_r  <= done_n_s;
        end
    end

    assign TX       = tx_r;
    assign TX_BUSY  = busy_r;
    assign TX_DONE  = done_r;
    assign TX_FULL  = full_r;
    assign TX_EMPTY = empty_r;
    assign TX_OVF   = ovf_r;

endmodule
